// File: rtl/game_input_conditioner.sv
// Purpose: cleans raw left/right/fire buttons into debounced move levels and a rate-limited fire strobe.
// Latency: 2 sync + DEBOUNCE_CYCLES clks to a level change; fire_pulse one clk after the debounced rise.
// Backpressure: none; outputs are levels and a one-clk event consumed by the renderer.
module game_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000,
  parameter int CNT_W           = 24
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_fire,
  output logic       move_left,
  output logic       move_right,
  output logic       fire_pulse,
  output logic [2:0] btn_state
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } fire_state_t;

  // Bit order {fire,right,left} throughout so btn_state is just the debounced vector.
  logic [2:0]       raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       db;
  logic [CNT_W-1:0] db_cnt [3];

  fire_state_t      state;
  logic [CNT_W-1:0] rep_cnt;
  logic             fire_prev;

  assign raw = {btn_fire, btn_right, btn_left};

  // Two-flop synchronizer per raw button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-button debounce: any disagreement shorter than DEBOUNCE_CYCLES restarts the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Fire FSM: a fresh debounced press fires at once, holding auto-repeats every REPEAT_CYCLES+1 clks.
  // fire_pulse is set on entry to FIRE, so it is high exactly while the FSM sits in FIRE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      fire_prev  <= 1'b0;
      fire_pulse <= 1'b0;
    end else begin
      fire_prev  <= db[2];
      fire_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (db[2] && !fire_prev) begin
            state      <= FIRE;
            fire_pulse <= 1'b1;
          end
        end
        FIRE: begin
          rep_cnt <= '0;
          state   <= HOLD;
        end
        HOLD: begin
          if (!db[2]) begin
            state <= IDLE;
          end else if (rep_cnt == RP_LAST) begin
            state      <= FIRE;
            fire_pulse <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Opposing directions cancel so the ship never gets both at once.
  assign move_left  = db[0] & ~db[1];
  assign move_right = db[1] & ~db[0];
  assign btn_state  = db;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Directed bench for game_input_conditioner with short debounce/repeat windows.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
// Expected cycle offsets are hand-derived: level at +10, first fire at +11, repeat every 21.
module tb_game_input_conditioner;

  localparam int DB = 8;
  localparam int RP = 20;

  logic       clk;
  logic       reset_n;
  logic       btn_left;
  logic       btn_right;
  logic       btn_fire;
  logic       move_left;
  logic       move_right;
  logic       fire_pulse;
  logic [2:0] btn_state;

  int n_checks = 0;
  int n_errors = 0;

  int pulses[$];
  int back_to_back;
  int bounce_pulses;

  game_input_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_fire  (btn_fire),
    .move_left (move_left),
    .move_right(move_right),
    .fire_pulse(fire_pulse),
    .btn_state (btn_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Steps n cycles, recording the 1-based offsets at which fire_pulse is seen high.
  task automatic watch(input int n);
    logic last;
    last = 1'b0;
    pulses.delete();
    back_to_back = 0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (fire_pulse) begin
        pulses.push_back(i);
        if (last) back_to_back++;
      end
      last = fire_pulse;
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    btn_left  = 1'b0;
    btn_right = 1'b0;
    btn_fire  = 1'b0;

    // Reset and idle
    step(3);
    check("rst_move_left", int'(move_left), 0);
    check("rst_move_right", int'(move_right), 0);
    check("rst_fire_pulse", int'(fire_pulse), 0);
    check("rst_btn_state", int'(btn_state), 0);
    reset_n = 1'b1;
    watch(12);
    check("idle_pulses", pulses.size(), 0);
    check("idle_btn_state", int'(btn_state), 0);
    check("idle_move_left", int'(move_left), 0);

    // Clean left press: rises 10 clks after the raw edge, falls 10 after release
    btn_left = 1'b1;
    step(9);
    check("left_before_10", int'(move_left), 0);
    step(1);
    check("left_at_10", int'(move_left), 1);
    step(20);
    check("left_held", int'(move_left), 1);
    check("left_state", int'(btn_state), 1);
    check("left_no_right", int'(move_right), 0);
    btn_left = 1'b0;
    step(9);
    check("left_rel_before_10", int'(move_left), 1);
    step(1);
    check("left_rel_at_10", int'(move_left), 0);

    // Fire bounce: 3-clk segments 1/0/1/0/1/0, then stable 1
    bounce_pulses = 0;
    for (int s = 0; s < 6; s++) begin
      btn_fire = (s % 2 == 0);
      watch(3);
      bounce_pulses += pulses.size();
    end
    check("bounce_no_pulse", bounce_pulses, 0);
    check("bounce_state", int'(btn_state), 0);
    btn_fire = 1'b1;

    // Held fire: first pulse at +11, then auto-repeat every 21 clks
    watch(75);
    check("fire_pulse_count", pulses.size(), 4);
    if (pulses.size() == 4) begin
      check("fire_t0", pulses[0], 11);
      check("fire_t1", pulses[1], 32);
      check("fire_t2", pulses[2], 53);
      check("fire_t3", pulses[3], 74);
    end
    check("fire_single_clk", back_to_back, 0);
    check("fire_state", int'(btn_state), 4);
    btn_fire = 1'b0;
    watch(12);
    check("fire_rel_pulses", pulses.size(), 0);
    check("fire_rel_state", int'(btn_state), 0);

    // Both directions held cancel; releasing right restores left
    btn_left  = 1'b1;
    btn_right = 1'b1;
    step(10);
    check("both_move_left", int'(move_left), 0);
    check("both_move_right", int'(move_right), 0);
    check("both_state", int'(btn_state), 3);
    btn_right = 1'b0;
    step(9);
    check("rel_right_before_10", int'(move_left), 0);
    step(1);
    check("rel_right_at_10", int'(move_left), 1);
    check("rel_right_move_right", int'(move_right), 0);
    btn_left = 1'b0;
    step(10);
    check("both_rel_state", int'(btn_state), 0);

    // Reset mid-HOLD with fire held: immediate clear, then full re-debounce
    btn_fire = 1'b1;
    watch(16);
    check("pre_rst_pulse_count", pulses.size(), 1);
    check("pre_rst_state", int'(btn_state), 4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_fire_pulse", int'(fire_pulse), 0);
    check("mid_rst_btn_state", int'(btn_state), 0);
    step(2);
    check("mid_rst_hold_state", int'(btn_state), 0);
    reset_n = 1'b1;
    watch(15);
    check("post_rst_pulse_count", pulses.size(), 1);
    if (pulses.size() == 1) check("post_rst_pulse_at", pulses[0], 11);
    btn_fire = 1'b0;
    step(12);
    check("final_state", int'(btn_state), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_input_conditioner.md
Name: game_input_conditioner

Overview:
- Sits directly upstream of the playfield/ship renderer in the space-shooter top level.
- Converts raw, bouncy, asynchronous board buttons (left, right, fire) into clean control signals in the clk domain:
  - debounced movement levels for left/right;
  - a rate-limited single-cycle fire strobe, with auto-repeat while fire is held.
- The renderer consumes move_left/move_right as levels and fire_pulse as a one-clk event.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles a synchronized input must be stable before the debounced level changes (10 ms at 50 MHz)
REPEAT_CYCLES, 12500000, clk cycles between auto-repeat fire pulses while fire is held (250 ms at 50 MHz)
CNT_W, 24, counter width; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
btn_left  input  1  raw left button, asynchronous, active-high
btn_right  input  1  raw right button, asynchronous, active-high
btn_fire  input  1  raw fire button, asynchronous, active-high
move_left  output  1  debounced left level, suppressed while right is also held
move_right  output  1  debounced right level, suppressed while left is also held
fire_pulse  output  1  one-clk fire strobe
btn_state  output  3  debounced levels {fire,right,left}, unqualified (LED/debug use)

Behaviour:
- Reset: asynchronous assert, synchronous release via the clk edge.
  - While reset_n=0: all synchronizer flops, debounced levels, counters and FSM state are 0/IDLE.
  - Outputs: move_left=0, move_right=0, fire_pulse=0, btn_state=3'b000.
- Synchronizer: each raw input passes through 2 flops, giving 2 cycles of metastability latency.
- Debounce, independently per button:
  - If the synchronized value equals the current debounced level, the counter clears to 0.
  - Otherwise the counter increments each clk.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES restarts the count from 0.
  - Total press latency from a raw edge to the debounced level: 2 + DEBOUNCE_CYCLES clks.
- Movement:
  - move_left = db_left & ~db_right; move_right = db_right & ~db_left.
  - Both held gives no motion. Combinational from the registered debounced levels.
- Fire FSM, states IDLE, FIRE, HOLD:
  - IDLE: db_fire rising (db_fire=1, previous=0) -> FIRE.
  - FIRE: fire_pulse=1 for exactly this one cycle; repeat counter loads 0 -> HOLD.
  - HOLD:
    - If db_fire=0 -> IDLE.
    - Else the counter increments; at REPEAT_CYCLES-1 -> FIRE (auto-repeat).
  - Release and re-press inside the repeat window fires immediately: the press passes through IDLE, so no cooldown is applied to distinct presses.
  - fire_pulse is registered: high in the cycle after the FSM enters FIRE, never high on 2 consecutive cycles.
- Counters saturate logically by the compare-and-clear rules above and never wrap.
- Reset mid-press:
  - All state clears immediately.
  - After release of reset, a still-held button must re-debounce the full DEBOUNCE_CYCLES before the level rises.
  - No fire_pulse is issued until a fresh debounced rising edge is seen.
- Button inputs are independent: simultaneous changes on several buttons are debounced in parallel with no interaction.

Test Plan:
- Parameters DEBOUNCE_CYCLES=8, REPEAT_CYCLES=20. Reset low 3 cycles, then high, all buttons 0 -> all outputs 0, btn_state=3'b000 throughout.
- Clean left press held 30 clks -> move_left rises exactly 10 clks after the raw edge (2 sync + 8) and stays 1. Release -> move_left falls 10 clks after the raw release.
- Bounce on fire: 0/1 toggling every 3 clks for 20 clks, then stable 1 -> no fire_pulse during the bounce; exactly one pulse about 10–11 clks after the last edge.
- Fire held 70 clks after debounce -> fire_pulse at t0, t0+21, t0+42, t0+63 (FIRE cycle + 20 HOLD counts), each one clk wide.
- Left and right both held and debounced -> move_left=0, move_right=0, btn_state=3'b011. Release right -> move_left=1 after 10 clks.
- Fire held, reset_n pulsed low for 2 clks mid-HOLD -> fire_pulse=0 and btn_state=0 immediately. With fire still held, the next fire_pulse occurs only after a full re-debounce of 10 clks after reset release.
